// File: rtl/rx_detect_sequencer_if.sv
// Receiver-detect bundle between the detect sequencer and the analog PHY / LTSSM.
interface rx_detect_sequencer_if #(
  parameter int unsigned NUM_LANES = 1
) ();
  logic                 enable;
  logic [NUM_LANES-1:0] rx_elec_idle_exit;
  logic                 det_req;
  logic                 det_ack;
  logic [NUM_LANES-1:0] det_result;
  logic [NUM_LANES-1:0] lane_detect;
  logic                 detect_valid;
  logic                 det_timeout;

  modport master (
    input  enable, rx_elec_idle_exit, det_ack, det_result,
    output det_req, lane_detect, detect_valid, det_timeout
  );

  modport slave (
    output enable, rx_elec_idle_exit, det_ack, det_result,
    input  det_req, lane_detect, detect_valid, det_timeout
  );
endinterface

// File: rtl/rx_detect_sequencer.sv
// Detect.Quiet / Detect.Active sequencer: quiet timer, PHY receiver-detect handshake
// and the two-pass partial-detect rule producing the per-lane detected-load vector.
module rx_detect_sequencer #(
  parameter int unsigned NUM_LANES    = 1,
  parameter int unsigned QUIET_CYCLES = 12000,
  parameter int unsigned ACK_TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  rx_detect_sequencer_if.master  bus
);

  localparam int unsigned CntMax = (QUIET_CYCLES > ACK_TIMEOUT) ? QUIET_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYCLES - 1);
  localparam logic [CntW-1:0] AckLast   = CntW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StQuiet  = 3'd1;
  localparam logic [2:0] StActive = 3'd2;
  localparam logic [2:0] StAckLow = 3'd3;
  localparam logic [2:0] StRetry  = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic [NUM_LANES-1:0] first_q, first_d;
  logic [NUM_LANES-1:0] res_q, res_d;
  logic                 det_req_q, det_req_d;
  logic [NUM_LANES-1:0] lane_q, lane_d;
  logic                 valid_q, valid_d;
  logic                 tmo_q, tmo_d;
  logic [NUM_LANES-1:0] final_res;

  // Second pass keeps only lanes that detected a load on both attempts.
  assign final_res = pass_q ? (first_q & res_q) : res_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    first_d   = first_q;
    res_d     = res_q;
    det_req_d = det_req_q;
    lane_d    = lane_q;
    valid_d   = valid_q;
    tmo_d     = 1'b0;

    if (!bus.enable) begin
      state_d   = StIdle;
      cnt_d     = '0;
      pass_d    = 1'b0;
      first_d   = '0;
      res_d     = '0;
      det_req_d = 1'b0;
      lane_d    = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StQuiet;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
        StQuiet: begin
          // A still-high ack from an earlier request blocks a new one.
          if ((cnt_q == QuietLast || (|bus.rx_elec_idle_exit)) && !bus.det_ack) begin
            state_d   = StActive;
            cnt_d     = '0;
            det_req_d = 1'b1;
          end else if (cnt_q != QuietLast) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StActive: begin
          if (bus.det_ack) begin
            res_d     = bus.det_result;
            det_req_d = 1'b0;
            state_d   = StAckLow;
          end else if (cnt_q == AckLast) begin
            det_req_d = 1'b0;
            tmo_d     = 1'b1;
            state_d   = StQuiet;
            cnt_d     = '0;
            pass_d    = 1'b0;
            first_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StAckLow: begin
          if (!bus.det_ack) begin
            if (final_res == '0) begin
              state_d = StQuiet;
              cnt_d   = '0;
              pass_d  = 1'b0;
              first_d = '0;
            end else if (!pass_q && res_q != '1) begin
              first_d = res_q;
              pass_d  = 1'b1;
              state_d = StRetry;
              cnt_d   = '0;
            end else begin
              state_d = StDone;
              lane_d  = final_res;
              valid_d = 1'b1;
            end
          end
        end
        StRetry: begin
          if (cnt_q == QuietLast) begin
            state_d   = StActive;
            cnt_d     = '0;
            det_req_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      first_q   <= '0;
      res_q     <= '0;
      det_req_q <= 1'b0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      first_q   <= first_d;
      res_q     <= res_d;
      det_req_q <= det_req_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.det_req      = det_req_q;
  assign bus.lane_detect  = lane_q;
  assign bus.detect_valid = valid_q;
  assign bus.det_timeout  = tmo_q;

endmodule
